// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Registered arbiter in front of the byte-wide sram controller. It has two
//   requesters: the host download path, which goes through a one-entry write
//   buffer, and the CPU bus, which uses a level-held strobe/ready handshake.
//   A buffered download write always beats the CPU. A cycle counter ends any
//   phase of mem_ready that hangs, and raises a sticky mem_err.
//
// Ports
//   clk_sys, reset             : clock, synchronous active-high reset
//   dl_active/dl_wr/dl_addr/dl_data : host download write port
//   dl_ce                      : host may issue dl_wr (buffer empty)
//   dl_overrun                 : sticky, a dl_wr arrived while buffer full
//   cpu_oe_n/cpu_we_n/cpu_addr/cpu_d : CPU access request, held until cpu_rdy
//   cpu_q/cpu_rdy              : CPU read data and completion
//   mem_addr/mem_din/mem_we/mem_rd : request to the sram controller
//   mem_dout/mem_ready         : response from the sram controller
//   mem_err                    : sticky timeout flag
module sram_port_arbiter #(
  parameter int AW      = 23,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_ce,
  output logic          dl_overrun,
  input  logic          cpu_oe_n,
  input  logic          cpu_we_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_d,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_rdy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ready,
  output logic          mem_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   cnt;

  logic          buf_full;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;

  logic          served;
  logic          own_cpu;
  logic          dir_rd;
  logic          dl_active_q;

  logic          cpu_req, cpu_wr, dl_pend, drain;
  logic          grant_dl, grant_cpu, issue;
  logic          ack_tmo, done_ok, done_tmo, finish, tmo;

  assign cpu_req = (~cpu_oe_n | ~cpu_we_n) & ~served;
  // When both strobes are low, the access is a write.
  assign cpu_wr  = ~cpu_we_n;
  // An incoming dl_wr counts as pending in the same cycle. This lets an idle
  // port issue it on the edge that also captures it into the buffer.
  assign dl_pend = buf_full | dl_wr;
  // The buffered write is on the bus this cycle, so its slot frees on this edge.
  assign drain   = mem_we & ~own_cpu;

  assign dl_ce   = ~buf_full;
  assign cpu_rdy = served;

  // ---- FSM state register ----
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- FSM next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (issue) state_nxt = ACK;
      ACK: begin
        if (!mem_ready)   state_nxt = DONE;
        else if (ack_tmo) state_nxt = IDLE;
      end
      DONE: if (done_ok || done_tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM output decode ----
  always_comb begin
    grant_dl  = 1'b0;
    grant_cpu = 1'b0;
    ack_tmo   = 1'b0;
    done_ok   = 1'b0;
    done_tmo  = 1'b0;
    case (state)
      IDLE: begin
        grant_dl  = mem_ready & dl_pend;
        grant_cpu = mem_ready & ~dl_pend & cpu_req & ~dl_active;
      end
      ACK:  ack_tmo = mem_ready & (cnt == TO_LAST);
      DONE: begin
        done_ok  = mem_ready;
        done_tmo = ~mem_ready & (cnt == TO_LAST);
      end
      default: ;
    endcase
    issue  = grant_dl | grant_cpu;
    tmo    = ack_tmo | done_tmo;
    finish = done_ok | tmo;
  end

  // ---- phase timeout counter ----
  // The counter restarts on every state change, so ACK and DONE each get the
  // full TIMEOUT budget.
  always_ff @(posedge clk_sys) begin
    if (reset || state == IDLE || state_nxt != state) cnt <= '0;
    else                                              cnt <= cnt + 16'd1;
  end

  // ---- download buffer control ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      buf_full    <= 1'b0;
      dl_overrun  <= 1'b0;
      dl_active_q <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      if (dl_wr && (!buf_full || drain)) buf_full <= 1'b1;
      else if (drain)                    buf_full <= 1'b0;
      if (dl_active && !dl_active_q)     dl_overrun <= 1'b0;
      if (dl_wr && buf_full && !drain)   dl_overrun <= 1'b1;
    end
  end

  // ---- download buffer data ----
  always_ff @(posedge clk_sys) begin
    if (dl_wr && (!buf_full || drain)) begin
      buf_addr <= dl_addr;
      buf_data <= dl_data;
    end
  end

  // ---- issue register ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      own_cpu  <= 1'b0;
      dir_rd   <= 1'b0;
    end else begin
      mem_we <= grant_dl | (grant_cpu & cpu_wr);
      mem_rd <= grant_cpu & ~cpu_wr;
      if (grant_dl) begin
        mem_addr <= buf_full ? buf_addr : dl_addr;
        mem_din  <= buf_full ? buf_data : dl_data;
        own_cpu  <= 1'b0;
        dir_rd   <= 1'b0;
      end else if (grant_cpu) begin
        mem_addr <= cpu_addr;
        mem_din  <= cpu_d;
        own_cpu  <= 1'b1;
        dir_rd   <= ~cpu_wr;
      end
    end
  end

  // ---- completion / CPU handshake ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      served  <= 1'b0;
      cpu_q   <= '0;
      mem_err <= 1'b0;
    end else begin
      if (finish && own_cpu)          served <= 1'b1;
      else if (cpu_oe_n && cpu_we_n)  served <= 1'b0;
      if (finish && own_cpu && dir_rd) cpu_q <= mem_dout;
      if (tmo)                         mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active, dl_wr;
  logic [22:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_ce, dl_overrun;
  logic        cpu_oe_n, cpu_we_n;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_d, cpu_q;
  logic        cpu_rdy;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_we, mem_rd, mem_err;
  logic        mem_ready = 1'b1;

  int nvec = 0;
  int nerr = 0;

  // memory model: mode 0 = drops ready for lat cycles after a strobe,
  // mode 1 = ready held low, mode 2 = ready held high
  int mode = 2;
  int lat = 3;
  int busy = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  logic [22:0] log_addr [0:31];
  logic [7:0]  log_data [0:31];

  sram_port_arbiter #(.AW(23), .DW(8), .TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_ce(dl_ce), .dl_overrun(dl_overrun),
    .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (mem_we) begin
      if (we_cnt < 32) begin
        log_addr[we_cnt] = mem_addr;
        log_data[we_cnt] = mem_din;
      end
      we_cnt++;
    end
    if (mem_rd) rd_cnt++;
    case (mode)
      0: begin
        if (mem_we || mem_rd) begin
          busy = lat;
          mem_ready = 1'b0;
        end else if (busy > 0) begin
          busy--;
          mem_ready = (busy == 0);
        end else begin
          mem_ready = 1'b1;
        end
      end
      1: mem_ready = 1'b0;
      default: mem_ready = 1'b1;
    endcase
  end

  task automatic test_reset();
    mode = 2;
    reset = 1'b1;
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_oe_n = 1'b1; cpu_we_n = 1'b1; cpu_addr = '0; cpu_d = '0;
    mem_dout = '0;
    repeat (3) @(negedge clk_sys);
    nvec++; if ({mem_we, mem_rd} !== 2'b00) begin nerr++; $display("FAIL reset_strobes: got %b want 00", {mem_we, mem_rd}); end
    nvec++; if (mem_addr !== 23'h0) begin nerr++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    nvec++; if (mem_din !== 8'h00) begin nerr++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
    nvec++; if (cpu_q !== 8'h00) begin nerr++; $display("FAIL reset_cpu_q: got %h want 00", cpu_q); end
    nvec++; if ({cpu_rdy, dl_ce, dl_overrun, mem_err} !== 4'b0100) begin nerr++; $display("FAIL reset_flags: got %b want 0100", {cpu_rdy, dl_ce, dl_overrun, mem_err}); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_download_burst();
    int base;
    mode = 0; lat = 3;
    dl_active = 1'b1;
    repeat (2) @(negedge clk_sys);
    base = we_cnt;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 50 && dl_ce !== 1'b1; k++) @(negedge clk_sys);
      nvec++; if (dl_ce !== 1'b1) begin nerr++; $display("FAIL burst_dl_ce_wait%0d: got %b want 1", i, dl_ce); end
      dl_wr = 1'b1; dl_addr = 23'(i); dl_data = 8'hA0 + 8'(i);
      @(negedge clk_sys);
      dl_wr = 1'b0;
      if (i == 0) begin
        nvec++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 23'h0, 8'hA0}) begin nerr++; $display("FAIL burst_first_issue: got we=%b a=%h d=%h want we=1 a=0 d=a0", mem_we, mem_addr, mem_din); end
        nvec++; if (dl_ce !== 1'b0) begin nerr++; $display("FAIL burst_dl_ce_busy: got %b want 0", dl_ce); end
      end
    end
    repeat (20) @(negedge clk_sys);
    nvec++; if (we_cnt - base !== 4) begin nerr++; $display("FAIL burst_we_count: got %0d want 4", we_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      nvec++; if ({log_addr[base+i], log_data[base+i]} !== {23'(i), 8'hA0 + 8'(i)}) begin nerr++; $display("FAIL burst_write%0d: got a=%h d=%h want a=%h d=%h", i, log_addr[base+i], log_data[base+i], i, 8'hA0 + 8'(i)); end
    end
    nvec++; if (dl_overrun !== 1'b0) begin nerr++; $display("FAIL burst_overrun: got %b want 0", dl_overrun); end
  endtask

  task automatic test_overrun();
    int base;
    mode = 1;
    repeat (2) @(negedge clk_sys);
    base = we_cnt;
    dl_wr = 1'b1; dl_addr = 23'h10; dl_data = 8'h11;
    @(negedge clk_sys);
    dl_addr = 23'h20; dl_data = 8'h22;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    nvec++; if (dl_ce !== 1'b0) begin nerr++; $display("FAIL overrun_dl_ce: got %b want 0", dl_ce); end
    nvec++; if (dl_overrun !== 1'b1) begin nerr++; $display("FAIL overrun_flag: got %b want 1", dl_overrun); end
    mode = 0;
    repeat (20) @(negedge clk_sys);
    nvec++; if (we_cnt - base !== 1) begin nerr++; $display("FAIL overrun_we_count: got %0d want 1", we_cnt - base); end
    nvec++; if ({log_addr[base], log_data[base]} !== {23'h10, 8'h11}) begin nerr++; $display("FAIL overrun_kept_write: got a=%h d=%h want a=10 d=11", log_addr[base], log_data[base]); end
    nvec++; if (dl_overrun !== 1'b1) begin nerr++; $display("FAIL overrun_sticky: got %b want 1", dl_overrun); end
    dl_active = 1'b0;
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys);
    nvec++; if (dl_overrun !== 1'b0) begin nerr++; $display("FAIL overrun_clear_on_rise: got %b want 0", dl_overrun); end
    dl_active = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_cpu_read();
    int base;
    mode = 0; lat = 3;
    mem_dout = 8'h5A;
    @(negedge clk_sys);
    base = rd_cnt;
    cpu_addr = 23'h004000; cpu_oe_n = 1'b0;
    @(negedge clk_sys);
    nvec++; if ({mem_rd, mem_we, mem_addr} !== {1'b1, 1'b0, 23'h004000}) begin nerr++; $display("FAIL read_issue: got rd=%b we=%b a=%h want rd=1 we=0 a=004000", mem_rd, mem_we, mem_addr); end
    repeat (3) @(negedge clk_sys);
    nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL read_rdy_early: got %b want 0", cpu_rdy); end
    @(negedge clk_sys);
    nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL read_rdy: got %b want 1", cpu_rdy); end
    nvec++; if (cpu_q !== 8'h5A) begin nerr++; $display("FAIL read_data: got %h want 5a", cpu_q); end
    repeat (5) @(negedge clk_sys);
    nvec++; if ({cpu_rdy, 8'(rd_cnt - base)} !== {1'b1, 8'd1}) begin nerr++; $display("FAIL read_hold: got rdy=%b rd_pulses=%0d want rdy=1 rd_pulses=1", cpu_rdy, rd_cnt - base); end
    cpu_oe_n = 1'b1;
    @(negedge clk_sys);
    nvec++; if (cpu_rdy !== 1'b0) begin nerr++; $display("FAIL read_release: got %b want 0", cpu_rdy); end
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic test_contention();
    int base;
    mode = 1;
    repeat (2) @(negedge clk_sys);
    base = we_cnt;
    dl_active = 1'b1;
    dl_wr = 1'b1; dl_addr = 23'h30; dl_data = 8'h33;
    @(negedge clk_sys);
    dl_wr = 1'b0; dl_active = 1'b0;
    cpu_we_n = 1'b0; cpu_addr = 23'h40; cpu_d = 8'h44;
    @(negedge clk_sys);
    mode = 0;
    for (int k = 0; k < 60 && cpu_rdy !== 1'b1; k++) @(negedge clk_sys);
    nvec++; if (cpu_rdy !== 1'b1) begin nerr++; $display("FAIL contention_rdy: got %b want 1", cpu_rdy); end
    cpu_we_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    nvec++; if (we_cnt - base !== 2) begin nerr++; $display("FAIL contention_count: got %0d want 2", we_cnt - base); end
    nvec++; if ({log_addr[base], log_data[base]} !== {23'h30, 8'h33}) begin nerr++; $display("FAIL contention_first_dl: got a=%h d=%h want a=30 d=33", log_addr[base], log_data[base]); end
    nvec++; if ({log_addr[base+1], log_data[base+1]} !== {23'h40, 8'h44}) begin nerr++; $display("FAIL contention_second_cpu: got a=%h d=%h want a=40 d=44", log_addr[base+1], log_data[base+1]); end
  endtask

  task automatic test_timeout();
    int base;
    mode = 2;
    mem_dout = 8'hC3;
    repeat (2) @(negedge clk_sys);
    base = rd_cnt;
    cpu_addr = 23'h55; cpu_oe_n = 1'b0;
    @(negedge clk_sys);
    nvec++; if (mem_rd !== 1'b1) begin nerr++; $display("FAIL timeout_issue: got %b want 1", mem_rd); end
    repeat (15) @(negedge clk_sys);
    nvec++; if ({mem_err, cpu_rdy} !== 2'b00) begin nerr++; $display("FAIL timeout_early: got err,rdy=%b want 00", {mem_err, cpu_rdy}); end
    @(negedge clk_sys);
    nvec++; if ({mem_err, cpu_rdy} !== 2'b11) begin nerr++; $display("FAIL timeout_fire: got err,rdy=%b want 11", {mem_err, cpu_rdy}); end
    nvec++; if (cpu_q !== 8'hC3) begin nerr++; $display("FAIL timeout_data: got %h want c3", cpu_q); end
    repeat (3) @(negedge clk_sys);
    nvec++; if (rd_cnt - base !== 1) begin nerr++; $display("FAIL timeout_no_reissue: got %0d want 1", rd_cnt - base); end
    cpu_oe_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    nvec++; if ({mem_err, cpu_rdy} !== 2'b10) begin nerr++; $display("FAIL timeout_sticky: got err,rdy=%b want 10", {mem_err, cpu_rdy}); end
  endtask

  task automatic test_reset_mid();
    mode = 0; lat = 6;
    mem_dout = 8'h99;
    repeat (2) @(negedge clk_sys);
    cpu_addr = 23'h66; cpu_oe_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    dl_wr = 1'b1; dl_addr = 23'h77; dl_data = 8'h78;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    nvec++; if ({dl_ce, cpu_rdy} !== 2'b00) begin nerr++; $display("FAIL midreset_precond: got dl_ce,rdy=%b want 00", {dl_ce, cpu_rdy}); end
    reset = 1'b1; cpu_oe_n = 1'b1;
    @(negedge clk_sys);
    nvec++; if ({mem_we, mem_rd, mem_addr, mem_din} !== {2'b00, 23'h0, 8'h00}) begin nerr++; $display("FAIL midreset_mem: got we=%b rd=%b a=%h d=%h want all 0", mem_we, mem_rd, mem_addr, mem_din); end
    nvec++; if ({cpu_q, cpu_rdy} !== {8'h00, 1'b0}) begin nerr++; $display("FAIL midreset_cpu: got q=%h rdy=%b want q=00 rdy=0", cpu_q, cpu_rdy); end
    nvec++; if ({dl_ce, dl_overrun, mem_err} !== 3'b100) begin nerr++; $display("FAIL midreset_flags: got %b want 100", {dl_ce, dl_overrun, mem_err}); end
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    nvec++; if ({cpu_rdy, dl_ce} !== 2'b01) begin nerr++; $display("FAIL midreset_after: got rdy,dl_ce=%b want 01", {cpu_rdy, dl_ce}); end
  endtask

  initial begin
    test_reset();
    test_download_burst();
    test_overrun();
    test_cpu_read();
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Sequences the single byte-wide SDRAM-backed SRAM port between the host ROM/image download path and the CPU memory bus. Today these are selected combinationally on `ioctl_download`. This block replaces that selection with a registered arbiter between the two requesters and the `sram` controller. It provides a one-entry download write buffer with host throttling, a CPU wait/ready handshake, and a completion timeout.

## Interface
Parameters:
- `AW`, 23: address width.
- `DW`, 8: data width.
- `TIMEOUT`, 255: maximum cycles to wait for any phase of `mem_ready`; range 1..65535.

Ports:
- `clk_sys` in 1: single clock for all logic. Runs at the same rate as the `sram` controller clock.
- `reset` in 1: synchronous reset, active-high.
- `dl_active` in 1: host download in progress.
- `dl_wr` in 1: one-cycle write strobe from the host.
- `dl_addr` in AW, `dl_data` in DW: download write address and data, valid with `dl_wr`.
- `dl_ce` out 1: host clock-enable. High while the buffer is empty, i.e. the host may issue `dl_wr`.
- `dl_overrun` out 1: sticky. Set when `dl_wr` arrives while the buffer is full; cleared by `reset` or by a rising edge of `dl_active`.
- `cpu_oe_n` in 1, `cpu_we_n` in 1: active-low CPU read/write levels, held until `cpu_rdy`.
- `cpu_addr` in AW, `cpu_d` in DW: CPU address and write data.
- `cpu_q` out DW: latched read data.
- `cpu_rdy` out 1: CPU access complete.
- `mem_addr` out AW, `mem_din` out DW: registered address and write data to the `sram` controller.
- `mem_we` out 1, `mem_rd` out 1: one-cycle request strobes to the `sram` controller.
- `mem_dout` in DW: read data from the `sram` controller.
- `mem_ready` in 1: `sram` controller idle/complete.
- `mem_err` out 1: sticky timeout flag; cleared by `reset` only.

## Operation
- Download buffer:
  - `dl_wr` with the buffer empty captures `dl_addr`/`dl_data` and sets `buf_full`.
  - `buf_full` clears in the cycle the buffered write is issued.
  - `dl_wr` with `buf_full=1` is dropped and sets `dl_overrun`.
  - `dl_ce = ~buf_full`.
- CPU request: `cpu_req = (~cpu_oe_n | ~cpu_we_n) & ~served`.
  - If both `cpu_oe_n` and `cpu_we_n` are low, the request is treated as a write.
  - `served` sets on completion.
  - `served` clears in the first cycle both `cpu_oe_n` and `cpu_we_n` are high.
- Priority: a buffered download write always wins over the CPU. While `dl_active=1`, CPU requests are not granted; `cpu_rdy` stays 0.
- FSM states: `IDLE`, `ACK`, `DONE`.
  - `IDLE`: when `mem_ready=1` and a grant exists, drive `mem_addr`/`mem_din` and pulse `mem_we` (download, or CPU write) or `mem_rd` (CPU read) for 1 cycle; go to `ACK`. Record the owner (DL or CPU) and the direction.
  - `ACK`: wait for `mem_ready=0`, then go to `DONE`.
  - `DONE`: wait for `mem_ready=1`. For a CPU read, latch `mem_dout` into `cpu_q` on that edge. For a CPU owner, set `served`. Go to `IDLE`.
- Timeout:
  - A counter clears on entry to `ACK` and on entry to `DONE`.
  - If the counter reaches `TIMEOUT` in either state: go to `IDLE`, set `mem_err`, and treat the access as complete (`served` set; for a read, `cpu_q` is loaded with `mem_dout` as sampled).
- `cpu_rdy = served`. It stays high until the CPU releases both strobes.
- `mem_addr`/`mem_din` hold their values outside of issue cycles.

## Timing
- Reset values:
  - `mem_we = mem_rd = 0`; `mem_addr = 0`; `mem_din = 0`.
  - `cpu_q = 0`; `cpu_rdy = 0`.
  - `dl_ce = 1`; `dl_overrun = 0`; `mem_err = 0`.
  - `buf_full = 0`; `served = 0`; FSM in `IDLE`.
- Reset mid-access: abandons the access without completing the CPU handshake.
- Issue latency, with `mem_ready=1` and the FSM idle:
  - `dl_wr` at cycle N → buffer captures at edge N → `mem_we` high in cycle N+1.
  - A CPU strobe first low in cycle N → `mem_rd`/`mem_we` high in cycle N+1.
- `cpu_rdy` rises in the cycle after `mem_ready` returns high in `DONE`. `cpu_q` is valid in the same cycle.
- Minimum access: 1 issue cycle + ≥1 cycle in `ACK` + ≥1 cycle in `DONE`.
- Strobes are never issued outside `IDLE` or while `mem_ready=0`. `mem_we` and `mem_rd` are never high together.
- Simultaneous `dl_wr` and buffer drain in the same cycle: the new write is accepted, because the drain frees the slot first.
- Simultaneous download-buffered and CPU requests: the download is issued; the CPU is issued next, in `IDLE`, only if `dl_active=0`.

## Test plan
- Download burst:
  - Stimulus: `dl_active=1`; 4 writes to 0x000000..0x000003 with data 0xA0..0xA3, each `dl_wr` issued only while `dl_ce=1`; memory model acks after 3 cycles.
  - Required: exactly 4 `mem_we` pulses with matching address/data; `dl_overrun=0`.
- Overrun:
  - Stimulus: two `dl_wr` on consecutive cycles while the memory holds `mem_ready=0`.
  - Required: the first write is buffered; `dl_overrun=1`; the second write never appears on `mem_addr`.
- CPU read:
  - Stimulus: `dl_active=0`; `cpu_oe_n=0` at `cpu_addr=0x004000`; memory returns 0x5A.
  - Required: one `mem_rd` pulse; `cpu_q=0x5A`; `cpu_rdy=1` until `cpu_oe_n=1`, then 0 the next cycle; no second `mem_rd` while the strobe is held.
- Contention:
  - Stimulus: CPU write and buffered download pending in the same cycle, with `dl_active=0` at grant.
  - Required: download `mem_we` first, then the CPU `mem_we`.
- Timeout:
  - Stimulus: `TIMEOUT=16`; memory never deasserts `mem_ready` after a CPU read strobe.
  - Required: FSM returns to `IDLE` after 16 cycles in `ACK`; `mem_err=1`; `cpu_rdy=1`.
- Reset mid-access:
  - Stimulus: assert `reset` while in `DONE`.
  - Required: all outputs at their reset values the next cycle; `buf_full=0`.
